// File: rtl/minority_pkg.sv
// Shared definitions for the minority-gate self-test checker.
//   state_e       : checker FSM states
//   NUM_VECTORS   : number of exhaustive 3-input test vectors
//   minority_of() : expected minority value of a 3-bit vector {a,b,c}
package minority_pkg;

  localparam int NUM_VECTORS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Minority = inverted majority: 1 when fewer than two inputs are high.
  function automatic logic minority_of(input logic [2:0] v);
    return ~((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
  endfunction

endpackage

// File: rtl/minority.sv
// Golden 3-input minority gate, used by the checker as the reference model.
//   a_i, b_i, c_i : gate inputs
//   y_o           : minority of the three inputs
module minority
  import minority_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_o
);

  assign y_o = minority_of({a_i, b_i, c_i});

endmodule

// File: rtl/minority_checker.sv
// Self-test sequencer for an external 3-input minority gate. A run walks the
// eight input vectors in order, holds each for SETTLE cycles, samples the
// gate output y for one cycle and records any mismatch against a golden
// minority instance.
//   clk, reset_n   : clock (rising edge) and async active-low reset
//   start          : single-cycle run request; accepted only in IDLE/DONE,
//                    there is no ready/acknowledge, busy reflects acceptance
//   y              : output of the gate under test
//   a, b, c        : stimulus to the gate under test ({a,b,c} = vector index)
//   busy/done/pass : run in progress / results valid / no mismatches
//   err_count      : number of mismatching vectors (0..8)
//   fail_vec       : bit i set when vector i mismatched
//   dbg_state      : current FSM state, for observation only
module minority_checker
  import minority_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec,
  output state_e     dbg_state
);

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] IDX_LAST  = 3'(NUM_VECTORS - 1);

  state_e     state_q;
  logic [2:0] idx_q;
  logic [3:0] wait_q;

  logic       exp_y;
  logic       mismatch;
  logic [3:0] err_d;
  logic [7:0] fail_d;

  // Reference fed from the registered stimulus, so it sees exactly what
  // the gate under test sees.
  minority u_golden (
    .a_i (a),
    .b_i (b),
    .c_i (c),
    .y_o (exp_y)
  );

  // Result update used at the closing edge of SAMPLE only.
  always_comb begin
    mismatch = (y != exp_y);
    err_d    = err_count + {3'b000, mismatch};
    fail_d   = fail_vec | (8'(mismatch) << idx_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      wait_q    <= 4'd0;
      {a, b, c} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 4'd0;
      fail_vec  <= 8'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= DRIVE;
            idx_q     <= 3'd0;
            wait_q    <= 4'd0;
            {a, b, c} <= 3'b000;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_vec  <= 8'd0;
          end
        end
        DRIVE: begin
          if (wait_q == WAIT_LAST) begin
            wait_q  <= 4'd0;
            state_q <= SAMPLE;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        SAMPLE: begin
          err_count <= err_d;
          fail_vec  <= fail_d;
          if (idx_q == IDX_LAST) begin
            // Last vector: index stays put, no wrap within a run.
            state_q   <= DONE;
            {a, b, c} <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_d == 4'd0);
          end else begin
            state_q   <= DRIVE;
            idx_q     <= idx_q + 3'd1;
            {a, b, c} <= idx_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_minority_checker.sv
// Bench for minority_checker: drives y from a programmable truth table that
// stands in for the external gate, and predicts results from the minority
// rule (fewer than two inputs high) evaluated per vector.
module tb_minority_checker;
  import minority_pkg::*;

  localparam int SETTLE   = 2;
  localparam int RUN_LEN  = 8 * (SETTLE + 1);

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       y;
  logic       a, b, c;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;
  state_e     dbg_state;

  logic [7:0] gate_tt;
  int         total;
  int         bad;

  minority_checker #(.SETTLE(SETTLE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .y         (y),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec),
    .dbg_state (dbg_state)
  );

  // Gate under test: output looked up from the current stimulus.
  assign y = gate_tt[{a, b, c}];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abc"},  {29'd0, a, b, c}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_err"},  {28'd0, err_count}, 32'd0);
    check({tag, "_fail"}, {24'd0, fail_vec}, 32'd0);
  endtask

  // Reference: vector i expects 1 when fewer than two of its bits are set.
  function automatic logic [7:0] model_fail(input logic [7:0] tt);
    logic [7:0] f;
    f = 8'd0;
    for (int i = 0; i < 8; i++) begin
      int ones;
      logic expv;
      ones = (i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1);
      expv = (ones < 2);
      if (tt[i] != expv) f[i] = 1'b1;
    end
    return f;
  endfunction

  // Driver: one complete run with a given gate truth table. When poke is
  // set, start is toggled randomly mid-run and must be ignored.
  task automatic run_and_check(input string name, input logic [7:0] tt, input bit poke);
    logic [7:0] exp_fail;
    int         exp_err;
    exp_fail = model_fail(tt);
    exp_err  = $countones(exp_fail);
    gate_tt  = tt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < RUN_LEN; k++) begin
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      check({name, "_done_early"}, {31'd0, done}, 32'd0);
      check({name, "_abc"}, {29'd0, a, b, c}, 32'(k / (SETTLE + 1)));
      if (k == 0) begin
        check({name, "_clr_err"}, {28'd0, err_count}, 32'd0);
        check({name, "_clr_fail"}, {24'd0, fail_vec}, 32'd0);
        check({name, "_clr_pass"}, {31'd0, pass}, 32'd0);
      end
      if (poke && k < RUN_LEN - 1) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    for (int h = 0; h < 3; h++) begin
      check({name, "_done"}, {31'd0, done}, 32'd1);
      check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
      check({name, "_pass"}, {31'd0, pass}, {31'd0, exp_err == 0});
      check({name, "_err"}, {28'd0, err_count}, 32'(exp_err));
      check({name, "_fail"}, {24'd0, fail_vec}, {24'd0, exp_fail});
      check({name, "_abc_end"}, {29'd0, a, b, c}, 32'd0);
      @(negedge clk);
    end
  endtask

  // Scoreboard of expected truth tables for the random runs.
  logic [7:0] exp_q[$];

  initial begin
    total   = 0;
    bad     = 0;
    start   = 1'b0;
    gate_tt = 8'h17;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle_wait");

    // Directed gates: correct, stuck-at-0, stuck-at-1, majority, correct.
    run_and_check("good",   8'h17, 1'b0);
    run_and_check("tied0",  8'h00, 1'b0);
    run_and_check("tied1",  8'hFF, 1'b0);
    run_and_check("major",  8'hE8, 1'b0);
    run_and_check("regood", 8'h17, 1'b0);

    // start held/toggled mid-run must not restart the sequence.
    run_and_check("poke", 8'h17, 1'b1);

    // Random faulty gates.
    for (int r = 0; r < 4; r++) exp_q.push_back(8'($urandom));
    while (exp_q.size() > 0) run_and_check("rand", exp_q.pop_front(), 1'b1);

    // Reset in the middle of vector 3 clears everything without a clock edge.
    gate_tt = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * (SETTLE + 1) + 1) @(negedge clk);
    check("mid_abc", {29'd0, a, b, c}, 32'd3);
    check("mid_err", {28'd0, err_count}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_rst");
    check("post_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    run_and_check("after_rst", 8'h17, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/minority_checker.md
MINORITY_CHECKER -- requirements
Module: minority_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the number of cycles each test vector is held before the output is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: requests a self-test run; sampled on the clk edge.
REQ-005 The block SHALL have port y, input, 1 bit: output of the external minority gate under test.
REQ-006 The block SHALL have ports a, b, c, output, 1 bit each: stimulus driven to the gate under test.
REQ-007 The block SHALL have port busy, output, 1 bit: run in progress.
REQ-008 The block SHALL have port done, output, 1 bit: run complete; results valid.
REQ-009 The block SHALL have port pass, output, 1 bit: done with zero mismatches.
REQ-010 The block SHALL have port err_count, output, 4 bits: number of mismatching vectors, range 0..8.
REQ-011 The block SHALL have port fail_vec, output, 8 bits: bit i set when vector i ({a,b,c}=i) mismatched.

Function
REQ-012 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-013 In IDLE or DONE, start=1 at a clk edge SHALL move the FSM to DRIVE, set vector index to 0, and clear err_count and fail_vec; busy=1, done=0 and pass=0 after that edge.
REQ-014 start SHALL be ignored in DRIVE and SAMPLE.
REQ-015 {a,b,c} SHALL equal the 3-bit vector index while busy, with a as the MSB, and 3'b000 in IDLE and DONE.
REQ-016 DRIVE SHALL last exactly SETTLE cycles per vector, counted by a wait counter, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle; at its closing edge the block compares y to the expected value, ~((a&b)|(a&c)|(b&c)).
REQ-018 On a mismatch, the same edge SHALL increment err_count and set fail_vec[index].
REQ-019 After SAMPLE, the block SHALL return to DRIVE with index+1 if index<7, otherwise go to DONE.
REQ-020 Vector index 7 SHALL be terminal; the index SHALL never wrap within a run.
REQ-021 A run SHALL take exactly 8*(SETTLE+1) cycles from the start edge to the edge entering DONE (24 cycles at the default).
REQ-022 In DONE: busy=0, done=1, and pass=(err_count==0); results SHALL hold until the next start or reset.
REQ-023 All outputs SHALL be registered, with no combinational path from y or start to any output.

Reset
REQ-024 reset_n=0 SHALL force, asynchronously: state IDLE; a=b=c=0; busy=0; done=0; pass=0; err_count=0; fail_vec=0; index=0; wait counter=0.
REQ-025 Reset asserted mid-run SHALL abort the run with no partial results kept.
REQ-026 After reset_n deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-027 Package minority_pkg SHALL hold the state enum, the constant NUM_VECTORS=8, and a function giving the expected minority value of a 3-bit vector.
REQ-028 The expected value SHALL come from one instance of the existing minority module, used as the golden model and fed the current {a,b,c}.
REQ-029 The block SHALL contain no other sub-modules.

Verification
REQ-030 Correct minority gate on y, SETTLE=2, start pulse -> done=1 exactly 24 cycles later, pass=1, err_count=0, fail_vec=8'h00.
REQ-031 y tied to 0 -> err_count=4, fail_vec=8'b00010111, pass=0.
REQ-032 y tied to 1 -> err_count=4, fail_vec=8'b11101000, pass=0.
REQ-033 Majority gate on y -> err_count=8, fail_vec=8'hFF; then start pulsed again with a correct gate -> results cleared, pass=1.
REQ-034 start re-asserted mid-run -> no restart, run still ends exactly 24 cycles after the first start edge.
REQ-035 reset_n pulsed low during vector 3 -> all outputs 0 immediately, without waiting for a clk edge; a new start gives a full 24-cycle run.
